// File: rtl/bandit_agent.sv
// Greedy multi-armed bandit agent with an action-value table.
// Issues one action at a time over a valid/ready stream, consumes one reward per
// action and moves the chosen arm's value toward the reward by 2^-ALPHA_SHIFT.
// Optional epsilon exploration is enabled with the BANDIT_AGENT_EXPLORE_EN macro.
module bandit_agent #(
  parameter int unsigned ARMS        = 256,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned ALPHA_SHIFT = 0,
  parameter int unsigned INIT_VALUE  = 0,
  parameter int unsigned EPSILON     = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reward_valid,
  input  logic [VALUE_WIDTH-1:0]  reward_data,
  output logic                    reward_ready,
  output logic                    action_valid,
  output logic [$clog2(ARMS)-1:0] action_data,
  input  logic                    action_ready
);

  localparam int unsigned AW = $clog2(ARMS);
  localparam logic [AW:0] IdxLast = (AW + 1)'(ARMS - 1);
  localparam logic [AW:0] IdxEnd  = (AW + 1)'(ARMS);

  typedef enum logic [2:0] {StInit, StScan, StAction, StReward, StUpdate} state_e;

  state_e                 state_q, state_d;
  logic [AW:0]            idx_q, idx_d;
  logic [VALUE_WIDTH-1:0] best_val_q, best_val_d;
  logic [AW-1:0]          best_idx_q, best_idx_d;
  logic                   action_valid_q, action_valid_d;
  logic                   reward_ready_q, reward_ready_d;
  logic [AW-1:0]          action_data_q, action_data_d;
  logic [VALUE_WIDTH-1:0] reward_q, reward_d;

  logic [VALUE_WIDTH-1:0] action_value_table [ARMS];
  logic                   tbl_we;
  logic [AW-1:0]          tbl_addr;
  logic [VALUE_WIDTH-1:0] tbl_wdata;

  logic [VALUE_WIDTH-1:0] scan_val;
  logic [VALUE_WIDTH-1:0] upd_cur;
  logic signed [VALUE_WIDTH:0] upd_diff;
  logic signed [VALUE_WIDTH:0] upd_shift;
  logic [VALUE_WIDTH-1:0] upd_val;
  logic [AW-1:0]          chosen_idx;

  assign scan_val = action_value_table[idx_q[AW-1:0]];
  assign upd_cur  = action_value_table[action_data_q];

  // Value update: Q + ((r - Q) >>> shift); result always fits, so truncation is exact.
  always_comb begin
    upd_diff  = $signed({1'b0, reward_q}) - $signed({1'b0, upd_cur});
    upd_shift = upd_diff >>> ALPHA_SHIFT;
    upd_val   = VALUE_WIDTH'({1'b0, upd_cur} + upd_shift);
  end

`ifdef BANDIT_AGENT_EXPLORE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every clock.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Random arm replaces the greedy pick when the low LFSR byte falls below EPSILON.
  always_comb begin
    if (lfsr_q[7:0] < 8'(EPSILON)) chosen_idx = lfsr_q[15 -: AW];
    else                           chosen_idx = best_idx_q;
  end

  // LFSR state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic [7:0] unused_epsilon;
  assign unused_epsilon = 8'(EPSILON);

  // Pure greedy selection.
  always_comb begin
    chosen_idx = best_idx_q;
  end
`endif

  // Next-state logic for the agent FSM and table write port.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    best_val_d     = best_val_q;
    best_idx_d     = best_idx_q;
    action_valid_d = action_valid_q;
    reward_ready_d = reward_ready_q;
    action_data_d  = action_data_q;
    reward_d       = reward_q;
    tbl_we         = 1'b0;
    tbl_addr       = idx_q[AW-1:0];
    tbl_wdata      = VALUE_WIDTH'(INIT_VALUE);
    unique case (state_q)
      StInit: begin
        tbl_we = 1'b1;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StScan;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StScan: begin
        if (idx_q == IdxEnd) begin
          // All entries compared; this is the extra cycle into ACTION.
          idx_d          = '0;
          state_d        = StAction;
          action_valid_d = 1'b1;
          action_data_d  = chosen_idx;
        end else begin
          // First entry seeds the running max; strict > keeps the lowest index on ties.
          if (idx_q == '0 || scan_val > best_val_q) begin
            best_val_d = scan_val;
            best_idx_d = idx_q[AW-1:0];
          end
          idx_d = idx_q + 1'b1;
        end
      end
      StAction: begin
        if (action_ready) begin
          action_valid_d = 1'b0;
          reward_ready_d = 1'b1;
          state_d        = StReward;
        end
      end
      StReward: begin
        if (reward_valid) begin
          reward_d       = reward_data;
          reward_ready_d = 1'b0;
          state_d        = StUpdate;
        end
      end
      StUpdate: begin
        tbl_we    = 1'b1;
        tbl_addr  = action_data_q;
        tbl_wdata = upd_val;
        idx_d     = '0;
        state_d   = StScan;
      end
      default: state_d = StInit;
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StInit;
      idx_q          <= '0;
      best_val_q     <= '0;
      best_idx_q     <= '0;
      action_valid_q <= 1'b0;
      reward_ready_q <= 1'b0;
      action_data_q  <= '0;
      reward_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      best_val_q     <= best_val_d;
      best_idx_q     <= best_idx_d;
      action_valid_q <= action_valid_d;
      reward_ready_q <= reward_ready_d;
      action_data_q  <= action_data_d;
      reward_q       <= reward_d;
    end
  end

  // Table storage; contents are rebuilt by INIT after every reset.
  always_ff @(posedge clock) begin
    if (tbl_we) action_value_table[tbl_addr] <= tbl_wdata;
  end

  assign action_valid = action_valid_q;
  assign reward_ready = reward_ready_q;
  assign action_data  = action_data_q;

endmodule

// File: tb/tb_bandit_agent.sv
// Bench for bandit_agent: two 4-arm instances (ALPHA_SHIFT 0 and 1, INIT_VALUE 100)
// driven with directed and random rewards, checked against an arithmetic model.
module tb_bandit_agent;

  localparam int ARMS = 4;
  localparam int VW   = 8;
  localparam int INIT = 100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [1:0]    rv, rr, av, ar;
  logic [VW-1:0] rd [2];
  logic [1:0]    ad [2];

  bandit_agent #(
    .ARMS(ARMS), .VALUE_WIDTH(VW), .ALPHA_SHIFT(0), .INIT_VALUE(INIT), .EPSILON(0)
  ) dut0 (
    .clock(clock), .reset(reset_n),
    .reward_valid(rv[0]), .reward_data(rd[0]), .reward_ready(rr[0]),
    .action_valid(av[0]), .action_data(ad[0]), .action_ready(ar[0])
  );

  bandit_agent #(
    .ARMS(ARMS), .VALUE_WIDTH(VW), .ALPHA_SHIFT(1), .INIT_VALUE(INIT), .EPSILON(0)
  ) dut1 (
    .clock(clock), .reset(reset_n),
    .reward_valid(rv[1]), .reward_data(rd[1]), .reward_ready(rr[1]),
    .action_valid(av[1]), .action_data(ad[1]), .action_ready(ar[1])
  );

  int checks = 0;
  int failures = 0;
  int q_model [2][ARMS];
  int alpha [2] = '{0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_q(input int d, input int a);
    if (d == 0) return int'(dut0.action_value_table[a]);
    return int'(dut1.action_value_table[a]);
  endfunction

  // Lowest index holding the maximum value.
  function automatic int best(input int d);
    int b = 0;
    for (int i = 1; i < ARMS; i++) if (q_model[d][i] > q_model[d][b]) b = i;
    return b;
  endfunction

  // q + floor((r - q) / 2^sh)
  function automatic int model_upd(input int q, input int r, input int sh);
    int diff = r - q;
    int p = 1 << sh;
    int f = diff / p;
    if (diff < 0 && (diff % p) != 0) f--;
    return q + f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) for (int i = 0; i < ARMS; i++) q_model[d][i] = INIT;
  endtask

  task automatic wait_av(input int d);
    int n = 0;
    while (!av[d] && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("action_valid_timeout", av[d], 1);
  endtask

  // Release reset at a negedge and count rising edges until each action_valid rises.
  task automatic release_and_measure();
    int e = 0;
    int lat [2] = '{0, 0};
    @(negedge clock);
    reset_n = 1'b1;
    while ((lat[0] == 0 || lat[1] == 0) && e < 50) begin
      @(posedge clock);
      e++;
      #1;
      for (int d = 0; d < 2; d++) if (lat[d] == 0 && av[d]) lat[d] = e;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("first_action_latency", lat[d], 2 * ARMS + 1);
      chk("first_action_data", ad[d], 0);
      chk("first_reward_ready", rr[d], 0);
      for (int i = 0; i < ARMS; i++) chk("init_table", get_q(d, i), INIT);
    end
  endtask

  task automatic do_round(input int d, input int r);
    int a;
    wait_av(d);
    a = best(d);
    chk("action_data", ad[d], a);
    ar[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ar[d] = 1'b0;
    chk("action_valid_after_hs", av[d], 0);
    chk("reward_ready_in_reward", rr[d], 1);
    rd[d] = VW'(r);
    rv[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rv[d] = 1'b0;
    chk("reward_ready_after_hs", rr[d], 0);
    q_model[d][a] = model_upd(q_model[d][a], r, alpha[d]);
    @(negedge clock);
    chk("table_after_update", get_q(d, a), q_model[d][a]);
  endtask

  initial begin
    int a0;
    reset_n = 1'b0;
    rv = '0;
    ar = '0;
    rd[0] = '0;
    rd[1] = '0;
    model_reset();
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_action_valid", av[d], 0);
      chk("reset_reward_ready", rr[d], 0);
      chk("reset_action_data", ad[d], 0);
    end

    release_and_measure();

    // Directed: reward 10 on arm 0 with alpha 1 -> Q[0]=10.
    do_round(0, 10);
    chk("directed_q0_alpha0", get_q(0, 0), 10);
    // Directed: alpha 1/2 -> Q[0]=50, then Q[1]=177.
    do_round(1, 0);
    chk("directed_q0_alpha1", get_q(1, 0), 50);
    do_round(1, 255);
    chk("directed_q1_alpha1", get_q(1, 1), 177);

    // Stall in ACTION with a stray reward pulse; nothing may change.
    wait_av(0);
    chk("stall_first_action", ad[0], 1);
    a0 = int'(ad[0]);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        rd[0] = VW'($urandom_range(0, 255));
        rv[0] = 1'b1;
      end else begin
        rv[0] = 1'b0;
      end
      @(negedge clock);
      chk("stall_action_valid", av[0], 1);
      chk("stall_action_data", ad[0], a0);
      chk("stall_reward_ready", rr[0], 0);
    end
    rv[0] = 1'b0;
    for (int i = 0; i < ARMS; i++) chk("stall_table_unchanged", get_q(0, i), q_model[0][i]);

    // Random rewards on both instances.
    for (int k = 0; k < 24; k++) do_round(k % 2, int'($urandom_range(0, 255)));

    // Reset mid-REWARD: outputs drop immediately, table rebuilt afterwards.
    for (int d = 0; d < 2; d++) begin
      wait_av(d);
      ar[d] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ar[d] = 1'b0;
      chk("pre_reset_reward_ready", rr[d], 1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_reset_reward_ready", rr[d], 0);
      chk("async_reset_action_valid", av[d], 0);
    end
    model_reset();
    release_and_measure();
    for (int k = 0; k < 6; k++) do_round(k % 2, int'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bandit_agent.md
Name: bandit_agent

Overview:
- Parametrised multi-armed bandit agent, successor to the fixed 256-arm/16-bit bandit.
- Holds an action-value table and issues actions over a valid/ready stream. Consumes one reward per action and updates the chosen arm's value with a configurable learning rate.
- Greedy selection by sequential argmax scan, with optimistic initial values.
- Sits between the environment/reward source and the action consumer.

Parameters:
- ARMS, 256, number of arms; power of 2, >= 2.
- VALUE_WIDTH, 16, width of reward and table entries (unsigned).
- ALPHA_SHIFT, 0, learning rate 2^-ALPHA_SHIFT; range 0..VALUE_WIDTH-1.
- INIT_VALUE, 0, value written to every table entry on reset.
- EPSILON, 0, 8-bit exploration threshold (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- reward_valid  in  1  reward beat valid.
- reward_data  in  VALUE_WIDTH  reward for the last issued action.
- reward_ready  out  1  agent accepts reward.
- action_valid  out  1  action beat valid.
- action_data  out  $clog2(ARMS)  chosen arm index.
- action_ready  in  1  consumer accepts action.

Behaviour:
- Storage: table named action_value_table[ARMS], VALUE_WIDTH each.
- Reset (reset low, asynchronous):
  - action_valid=0, reward_ready=0, action_data=0, state=INIT, index counter=0.
  - Takes effect immediately, including mid-handshake or mid-scan.
- INIT:
  - Writes INIT_VALUE to entry `idx`, one entry per clock; ARMS cycles; then SCAN.
- SCAN:
  - Compares one entry per clock over ARMS cycles and tracks best value and index.
  - Strict greater-than compare, so ties resolve to the lowest index.
  - Next edge enters ACTION.
- Latency: action_valid rises on the 2*ARMS+1-th rising edge after reset deassertion.
- ACTION:
  - action_valid=1; action_data held stable until action_valid && action_ready on a rising edge.
  - After the handshake, action_valid=0 on the next cycle and state=REWARD.
- REWARD:
  - reward_ready=1; waits for reward_valid.
  - On the handshake edge: latch reward_data, reward_ready=0, go to UPDATE.
  - Rewards presented in any other state are ignored (reward_ready=0).
- UPDATE (1 cycle):
  - Compute d = signed(reward) - signed(Q[a]) in VALUE_WIDTH+1 bits.
  - Q[a] <= Q[a] + (d >>> ALPHA_SHIFT); arithmetic shift rounds toward -inf.
  - Result always lies in [0, 2^VALUE_WIDTH-1]; no saturation logic needed.
  - Then SCAN.
- Action-to-action latency: handshake, then reward wait, then 1 UPDATE cycle + ARMS SCAN cycles + 1 cycle to ACTION.
- No simultaneous reward/action acceptance; only one of action_valid or reward_ready is ever high.

Optional Feature:
- Macro: BANDIT_AGENT_EXPLORE_EN.
- With the macro:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, advances every clock.
  - On SCAN exit: if lfsr[7:0] < EPSILON, action_data = lfsr[15 -: $clog2(ARMS)] (exploration); otherwise the greedy index.
  - EPSILON=0 is identical to greedy.
- Without the macro: no LFSR logic, EPSILON is ignored, always greedy.

Test Plan:
- ARMS=4, INIT_VALUE=100, ALPHA_SHIFT=0; release reset, action_ready=1 -> action_valid on edge 9, action_data=0, all table entries 100.
- Same config; reward 10 after action 0 -> Q[0]=10; next action_data=1 (lowest index of the max 100).
- ALPHA_SHIFT=1, INIT_VALUE=100; reward 0 on arm 0 -> Q[0]=50; then reward 255 on arm 1 -> Q[1]=177.
- action_ready held low 5 cycles -> action_valid=1 and action_data constant throughout; reward_valid pulsed during ACTION -> no table change, reward_ready=0.
- reset pulsed low during REWARD -> reward_ready=0 and action_valid=0 immediately; after release the table is re-initialised to INIT_VALUE and the first action is 0 after 9 edges.
- BANDIT_AGENT_EXPLORE_EN, ARMS=4: EPSILON=0 -> 32 actions identical to the greedy run; EPSILON=255, INIT_VALUE=0, reward 0 always -> at least 3 distinct arms over 64 actions.
